// File: rtl/sobel_ctrl_pkg.sv
// ============================================================================
//  Module      : sobel_ctrl_pkg
//  Description : Shared types and constants for the sobel frame controller:
//                FSM state encoding, default image geometry and the width
//                of the frame-buffer addresses.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package sobel_ctrl_pkg;

    // Frame-buffer address width (covers up to 128K pixels).
    localparam int c_addr_w     = 17;

    // Default image geometry (QVGA).
    localparam int c_img_w_dflt = 320;
    localparam int c_img_h_dflt = 240;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sobel_valid_delay.sv
// ============================================================================
//  Module      : sobel_valid_delay
//  Description : DEPTH-cycle shift register carrying the pixel-valid flag
//                alongside the sobel datapath latency.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous reset, active-low
//                clr  - synchronous clear of every stage (frame abort)
//                din  - valid flag into the sobel datapath
//                dout - valid flag aligned with the sobel result
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sobel_valid_delay #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic din,
    output logic dout
);

    generate
        if (DEPTH == 1) begin : g_single
            logic r_q;
            always_ff @(posedge clk) begin
                if (!rst || clr) r_q <= 1'b0;
                else             r_q <= din;
            end
            assign dout = r_q;
        end else begin : g_shift
            logic [DEPTH-1:0] r_pipe;
            always_ff @(posedge clk) begin
                if (!rst || clr) r_pipe <= '0;
                else             r_pipe <= {r_pipe[DEPTH-2:0], din};
            end
            assign dout = r_pipe[DEPTH-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/sobel_frame_ctrl.sv
// ============================================================================
//  Module      : sobel_frame_ctrl
//  Description : Streams one IMG_W x IMG_H grey frame from the source buffer
//                through an external sobel datapath (latency SOB_LAT) and
//                writes the results sequentially into the result buffer.
//  Ports       : clk, rst (sync, active-low)
//                start/abort/thr_in       - frame control, edge threshold
//                src_addr/src_rdata       - source read (1-cycle latency)
//                sob_dval/sob_data/sob_thr/sob_odata - sobel datapath
//                dst_we/dst_addr/dst_wdata - result buffer write
//                busy, done (pulse), frame_cnt (completed frames, wraps)
//  Options     : SOBEL_BORDER_ZERO_EN - force results on the image border
//                (first/last column, first/last row) to zero.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sobel_frame_ctrl
    import sobel_ctrl_pkg::*;
#(
    parameter int IMG_W   = c_img_w_dflt,
    parameter int IMG_H   = c_img_h_dflt,
    parameter int SOB_LAT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [7:0]          thr_in,
    output logic [c_addr_w-1:0] src_addr,
    input  logic [7:0]          src_rdata,
    output logic                sob_dval,
    output logic [9:0]          sob_data,
    output logic [7:0]          sob_thr,
    input  logic [9:0]          sob_odata,
    output logic                dst_we,
    output logic [c_addr_w-1:0] dst_addr,
    output logic [7:0]          dst_wdata,
    output logic                busy,
    output logic                done,
    output logic [15:0]         frame_cnt
);

    localparam logic [c_addr_w-1:0] c_last_addr = c_addr_w'(IMG_W * IMG_H - 1);
    localparam logic [c_addr_w-1:0] c_one       = c_addr_w'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_addr_w-1:0] r_src_addr;
    logic [c_addr_w-1:0] r_dst_addr;
    logic                r_sob_dval;
    logic [7:0]          r_sob_thr;
    logic                r_done;
    logic [15:0]         r_frame_cnt;
    logic                w_accept;
    logic                w_dst_we;
    logic                w_last_wr;
    logic                w_busy;
    logic                w_unused_lsbs;

    assign w_accept  = (r_state == ST_IDLE) && start && !abort;
    assign w_last_wr = w_dst_we && (r_dst_addr == c_last_addr);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_FEED;
            end
            ST_FEED: begin
                w_busy = 1'b1;
                if (r_src_addr == c_last_addr) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (w_last_wr) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Abort overrides every transition, including a simultaneous start.
        if (abort) w_state_nxt = ST_IDLE;
    end

    // ------------------------------------------------------------------
    // Address generation, valid tracking, frame bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_src_addr  <= '0;
            r_dst_addr  <= '0;
            r_sob_dval  <= 1'b0;
            r_sob_thr   <= 8'h00;
            r_done      <= 1'b0;
            r_frame_cnt <= 16'h0000;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_src_addr <= '0;
                r_dst_addr <= '0;
                r_sob_dval <= 1'b0;
            end else begin
                // Source data arrives one cycle after its address, so the
                // valid flag is simply the FEED state delayed by one cycle.
                r_sob_dval <= (r_state == ST_FEED);

                if (w_accept) begin
                    r_src_addr <= '0;
                    r_dst_addr <= '0;
                    r_sob_thr  <= thr_in;
                end else if (r_state == ST_FEED) begin
                    r_src_addr <= (r_src_addr == c_last_addr) ? '0 : r_src_addr + c_one;
                end

                if (w_dst_we) begin
                    r_dst_addr <= w_last_wr ? '0 : r_dst_addr + c_one;
                end

                if ((r_state == ST_DRAIN) && w_last_wr) begin
                    r_done      <= 1'b1;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end
            end
        end
    end

    sobel_valid_delay #(
        .DEPTH (SOB_LAT)
    ) u_valid_delay (
        .clk   (clk),
        .rst   (rst),
        .clr   (abort),
        .din   (r_sob_dval),
        .dout  (w_dst_we)
    );

    // ------------------------------------------------------------------
    // Result data path
    // ------------------------------------------------------------------
`ifdef SOBEL_BORDER_ZERO_EN
    localparam logic [c_addr_w-1:0] c_col_last = c_addr_w'(IMG_W - 1);
    localparam logic [c_addr_w-1:0] c_row_last = c_addr_w'(IMG_H - 1);

    logic [c_addr_w-1:0] r_col;
    logic [c_addr_w-1:0] r_row;
    logic                w_border;

    // Column/row of the pixel currently presented on the write port.
    always_ff @(posedge clk) begin
        if (!rst || abort || w_accept) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_dst_we) begin
            if (r_col == c_col_last) begin
                r_col <= '0;
                r_row <= (r_row == c_row_last) ? '0 : r_row + c_one;
            end else begin
                r_col <= r_col + c_one;
            end
        end
    end

    assign w_border  = (r_col == '0) || (r_col == c_col_last) ||
                       (r_row == '0) || (r_row == c_row_last);
    assign dst_wdata = (w_dst_we && !w_border) ? sob_odata[9:2] : 8'h00;
`else
    assign dst_wdata = w_dst_we ? sob_odata[9:2] : 8'h00;
`endif

    // Fractional result bits are dropped on the 8-bit result buffer.
    assign w_unused_lsbs = ^sob_odata[1:0];

    assign src_addr  = r_src_addr;
    assign sob_dval  = r_sob_dval;
    assign sob_data  = r_sob_dval ? {src_rdata, 2'b00} : 10'h000;
    assign sob_thr   = r_sob_thr;
    assign dst_we    = w_dst_we;
    assign dst_addr  = r_dst_addr;
    assign busy      = w_busy;
    assign done      = r_done;
    assign frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sobel_frame_ctrl.sv
// ============================================================================
//  Module      : tb_sobel_frame_ctrl
//  Description : Directed self-checking bench for sobel_frame_ctrl with an
//                8x4 image and a 3-cycle sobel model that echoes its input.
//                The source memory returns pixel value = address (ramp).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sobel_frame_ctrl;

    localparam int W   = 8;
    localparam int H   = 4;
    localparam int LAT = 3;
    localparam int N   = W * H;

    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic        start  = 1'b0;
    logic        abort  = 1'b0;
    logic [7:0]  thr_in = 8'h00;
    logic [16:0] src_addr;
    logic [7:0]  src_rdata = 8'h00;
    logic        sob_dval;
    logic [9:0]  sob_data;
    logic [7:0]  sob_thr;
    logic [9:0]  sob_odata;
    logic        dst_we;
    logic [16:0] dst_addr;
    logic [7:0]  dst_wdata;
    logic        busy;
    logic        done;
    logic [15:0] frame_cnt;

    logic [9:0]  sob_pipe [LAT] = '{default: 10'h000};

    int tests_run    = 0;
    int tests_failed = 0;

    int          wr_cnt   = 0;
    int          dval_cnt = 0;
    int          done_cnt = 0;
    logic [16:0] wr_addr_log [1024];
    logic [7:0]  wr_data_log [1024];

    always #5 clk = ~clk;

    sobel_frame_ctrl #(
        .IMG_W   (W),
        .IMG_H   (H),
        .SOB_LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .thr_in    (thr_in),
        .src_addr  (src_addr),
        .src_rdata (src_rdata),
        .sob_dval  (sob_dval),
        .sob_data  (sob_data),
        .sob_thr   (sob_thr),
        .sob_odata (sob_odata),
        .dst_we    (dst_we),
        .dst_addr  (dst_addr),
        .dst_wdata (dst_wdata),
        .busy      (busy),
        .done      (done),
        .frame_cnt (frame_cnt)
    );

    // Source memory (ramp, 1-cycle read) and echoing sobel model.
    always @(posedge clk) begin
        src_rdata   <= src_addr[7:0];
        sob_pipe[0] <= sob_data;
        for (int i = 1; i < LAT; i++) sob_pipe[i] <= sob_pipe[i-1];
    end
    assign sob_odata = sob_pipe[LAT-1];

    // Passive monitor: logs every result write and counts events.
    always @(negedge clk) begin
        if (sob_dval) dval_cnt = dval_cnt + 1;
        if (done)     done_cnt = done_cnt + 1;
        if (dst_we) begin
            if (wr_cnt < 1024) begin
                wr_addr_log[wr_cnt] = dst_addr;
                wr_data_log[wr_cnt] = dst_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    function automatic logic [7:0] exp_pix(int i);
`ifdef SOBEL_BORDER_ZERO_EN
        int c;
        int r;
        c = i % W;
        r = i / W;
        if (c == 0 || c == W - 1 || r == 0 || r == H - 1) return 8'h00;
`endif
        return 8'(i);
    endfunction

    // Number of logged writes, starting at log index 'from', that deviate
    // from the expected address sequence 0..N-1 and pixel values.
    function automatic int bad_writes(int from);
        int bad;
        bad = 0;
        for (int j = 0; j < N; j++) begin
            if (from + j >= 1024) bad++;
            else if (wr_addr_log[from+j] !== 17'(j) || wr_data_log[from+j] !== exp_pix(j)) bad++;
        end
        return bad;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    // Returns on the first FEED cycle (t = 0).
    task automatic start_frame(input logic [7:0] thr);
        @(negedge clk);
        thr_in = thr;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Cycle counts are relative to the negedge on which this task is entered.
    task automatic wait_done(output int t, output int first_we);
        t        = -1;
        first_we = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (dst_we && first_we < 0) first_we = k + 1;
            if (done) begin
                t = k + 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({src_addr, dst_addr} !== 34'h0) begin
            tests_failed++;
            $display("FAIL reset_addr: src=%0h dst=%0h expected 0 0", src_addr, dst_addr);
        end
        tests_run++;
        if ({sob_dval, dst_we, busy, done} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: dval/we/busy/done=%b expected 0000", {sob_dval, dst_we, busy, done});
        end
        tests_run++;
        if ({sob_data, dst_wdata, sob_thr, frame_cnt} !== 42'h0) begin
            tests_failed++;
            $display("FAIL reset_data: sob_data=%0h wdata=%0h thr=%0h fcnt=%0h expected all 0",
                     sob_data, dst_wdata, sob_thr, frame_cnt);
        end
        rst = 1'b1;
    endtask

    task automatic test_frame();
        int ws, dv, dn, t, fw;
        @(negedge clk);
        #1;
        ws = wr_cnt; dv = dval_cnt; dn = done_cnt;
        start_frame(8'hF0);
        tests_run++;
        if (busy !== 1'b1 || src_addr !== 17'd0) begin
            tests_failed++;
            $display("FAIL frame_start: busy=%b src_addr=%0d expected 1 0", busy, src_addr);
        end
        wait_done(t, fw);
        tests_run++;
        if (fw !== 4) begin
            tests_failed++;
            $display("FAIL first_we_latency: got %0d cycles expected 4", fw);
        end
        tests_run++;
        if (t !== 36) begin
            tests_failed++;
            $display("FAIL done_cycle: got %0d expected 36", t);
        end
        tests_run++;
        if (frame_cnt !== 16'd1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL frame_end: frame_cnt=%0d busy=%b expected 1 0", frame_cnt, busy);
        end
        tests_run++;
        if (sob_thr !== 8'hF0) begin
            tests_failed++;
            $display("FAIL sob_thr: got %0h expected f0", sob_thr);
        end
        repeat (5) @(negedge clk);
        #1;
        tests_run++;
        if (dval_cnt - dv !== N || wr_cnt - ws !== N) begin
            tests_failed++;
            $display("FAIL frame_counts: dval=%0d writes=%0d expected %0d %0d", dval_cnt - dv, wr_cnt - ws, N, N);
        end
        tests_run++;
        if (done_cnt - dn !== 1) begin
            tests_failed++;
            $display("FAIL done_pulses: got %0d expected 1", done_cnt - dn);
        end
        tests_run++;
        if (bad_writes(ws) !== 0) begin
            tests_failed++;
            $display("FAIL frame_data: %0d bad writes expected 0", bad_writes(ws));
        end
    endtask

    task automatic test_abort();
        int ws, dn, t, fw;
        apply_reset();
        @(negedge clk);
        #1;
        ws = wr_cnt; dn = done_cnt;
        start_frame(8'h5A);
        for (int k = 0; k < 200; k++) begin
            if (dst_we && dst_addr == 17'd10) break;
            @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        tests_run++;
        if ({busy, dst_we, sob_dval} !== 3'b000) begin
            tests_failed++;
            $display("FAIL abort_idle: busy/we/dval=%b expected 000", {busy, dst_we, sob_dval});
        end
        repeat (40) @(negedge clk);
        #1;
        tests_run++;
        if (wr_cnt - ws !== 11 || done_cnt - dn !== 0 || frame_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL abort_quiet: writes=%0d done=%0d fcnt=%0d expected 11 0 0",
                     wr_cnt - ws, done_cnt - dn, frame_cnt);
        end
        ws = wr_cnt;
        start_frame(8'h5B);
        wait_done(t, fw);
        #1;
        tests_run++;
        if (t !== 36 || frame_cnt !== 16'd1 || bad_writes(ws) !== 0) begin
            tests_failed++;
            $display("FAIL abort_restart: done_t=%0d fcnt=%0d bad=%0d expected 36 1 0", t, frame_cnt, bad_writes(ws));
        end
    endtask

    task automatic test_back_to_back();
        int ws, t, fw;
        apply_reset();
        start_frame(8'h22);
        repeat (5) @(negedge clk);
        thr_in = 8'h11;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        tests_run++;
        if (sob_thr !== 8'h22 || src_addr !== 17'd6) begin
            tests_failed++;
            $display("FAIL busy_start_ignored: thr=%0h src_addr=%0d expected 22 6", sob_thr, src_addr);
        end
        wait_done(t, fw);
        tests_run++;
        if (t !== 30) begin
            tests_failed++;
            $display("FAIL frame1_length: done after %0d expected 30", t);
        end
        thr_in = 8'h33;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        #1;
        ws = wr_cnt;
        tests_run++;
        if (busy !== 1'b1 || sob_thr !== 8'h33 || src_addr !== 17'd0) begin
            tests_failed++;
            $display("FAIL done_cycle_start: busy=%b thr=%0h src_addr=%0d expected 1 33 0", busy, sob_thr, src_addr);
        end
        wait_done(t, fw);
        #1;
        tests_run++;
        if (t !== 36 || frame_cnt !== 16'd2 || bad_writes(ws) !== 0) begin
            tests_failed++;
            $display("FAIL frame2: done_t=%0d fcnt=%0d bad=%0d expected 36 2 0", t, frame_cnt, bad_writes(ws));
        end
    endtask

    task automatic test_reset_mid_drain();
        int ws, dn;
        start_frame(8'h44);
        repeat (33) @(negedge clk);
        tests_run++;
        if (busy !== 1'b1 || dst_we !== 1'b1 || frame_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL drain_pre: busy=%b we=%b fcnt=%0d expected 1 1 2", busy, dst_we, frame_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({src_addr, dst_addr, sob_dval, dst_we, busy, done} !== 38'h0 ||
            {sob_data, dst_wdata, sob_thr, frame_cnt} !== 42'h0) begin
            tests_failed++;
            $display("FAIL drain_reset: src=%0h dst=%0h flags=%b data=%0h wd=%0h thr=%0h fcnt=%0h expected all 0",
                     src_addr, dst_addr, {sob_dval, dst_we, busy, done}, sob_data, dst_wdata, sob_thr, frame_cnt);
        end
        rst = 1'b1;
        #1;
        ws = wr_cnt; dn = done_cnt;
        repeat (20) @(negedge clk);
        #1;
        tests_run++;
        if (wr_cnt - ws !== 0 || done_cnt - dn !== 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_quiet: writes=%0d done=%0d busy=%b expected 0 0 0", wr_cnt - ws, done_cnt - dn, busy);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_abort();
        test_back_to_back();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
